vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, successor to the fixed 640x480@60 timer. Porches, sync widths, active area, pixel clock divisor and sync polarities are all parameters. Adds a clock enable, a per-pixel strobe, a line-start strobe and a frame counter. It drives HS/VS and the pixel x/y/blank bus consumed by the raster and framebuffer logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, HS pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, VS pulse width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 4, clk cycles per pixel (>=1; 4 gives 25 MHz from 100 MHz)
HS_POL, 0, HS active level (0 = active-low)
VS_POL, 0, VS active level
CW, 10, width of x/y (must hold H_TOTAL-1 and V_TOTAL-1)
FCW, 8, frame counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; 0 freezes all timing state
HS  out  1  horizontal sync, polarity per HS_POL
VS  out  1  vertical sync, polarity per VS_POL
x  out  CW  current pixel column, 0..H_TOTAL-1
y  out  CW  current line, 0..V_TOTAL-1
blank  out  1  1 outside the active area
pix_en  out  1  1 on the first clk of each pixel period
newline  out  1  1 on the first clk of x==0 (every line)
newframe  out  1  1 on the first clk of x==0,y==0
endframe  out  1  1 on the first clk of x==0,y==V_ACTIVE
frame_cnt  out  FCW  frames started since reset, modulo 2^FCW

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Internal prescaler p counts 0..CLK_DIV-1. tick = en & (p==CLK_DIV-1). When CLK_DIV==1, tick = en.
- On tick: p goes to 0 and x increments. When x==H_TOTAL-1, x goes to 0 and y increments. When y==V_TOTAL-1 at the same point, y goes to 0. Otherwise, with en=1 and no tick, p increments.
- With en=0, p, x, y, HS, VS, blank and frame_cnt all hold. pix_en, newline, newframe and endframe are 0.
- All outputs are registered. They are decoded from next-state values, so HS, VS, blank and the strobes are aligned with x/y in the same cycle (zero skew, no extra pipeline stage).
- blank = (x >= H_ACTIVE) | (y >= V_ACTIVE).
- HS is active when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; otherwise inactive (~HS_POL).
- VS is active when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; otherwise inactive.
- Strobes (each is en-qualified and high for exactly one clk):
  - pix_en: high when p==0.
  - newline: high when p==0 & x==0.
  - newframe: high when p==0 & x==0 & y==0.
  - endframe: high when p==0 & x==0 & y==V_ACTIVE.
- frame_cnt increments, wrapping, in the same cycle that newframe is high.
- Reset state (asynchronous, applied immediately):
  - p=CLK_DIV-1, x=H_TOTAL-1, y=V_TOTAL-1.
  - blank=1, HS and VS inactive.
  - All strobes 0, frame_cnt all-ones.
- The first clk with en=1 after reset release lands on x=0,y=0,p=0 with newframe=1, newline=1, pix_en=1, blank=0 and frame_cnt=0.
- Reset asserted mid-frame forces the reset state at once, independent of clk. Timing restarts from the frame origin on the first enabled clk after release.
- en toggling mid-pixel resumes at the frozen p. Pixel periods always contain exactly CLK_DIV enabled clks.
- Parameter sanity (all widths >=1, CW large enough) is checked at elaboration and is a fatal error if violated. No runtime checking.

Test Plan:
- Defaults, en=1 after reset:
  - 1st clk: x=0, y=0, newframe=1, pix_en=1, frame_cnt=0, blank=0, HS=1, VS=1.
  - pix_en every 4th clk thereafter.
- Defaults, one line: HS falls when x becomes 656 and rises when x becomes 752; newline period is 3200 clks; blank rises at x=640.
- Defaults, one frame:
  - VS low for y=490..491 only.
  - endframe at x=0,y=480.
  - newframe period 1,680,000 clks; frame_cnt=1 at the second newframe.
- Small config (H 8/1/2/1, V 4/1/1/1, CLK_DIV=1, HS_POL=1, VS_POL=1):
  - 84-clk frame, pix_en constant 1.
  - HS high exactly at x=9..10; VS high exactly at y=5.
  - After 256 frames, frame_cnt wraps 255->0.
- Drop en for 7 clks mid-pixel (defaults): x, y, HS, VS, blank and frame_cnt hold; strobes are 0. After resume, the pixel finishes in its remaining enabled clks.
- Assert rst_n=0 mid-line with no clk edge: outputs take the reset state immediately (blank=1, HS/VS inactive). On release, the first en clk gives newframe=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: prescaled pixel counter, x/y raster
// position, sync/blank decode, line/frame strobes and a frame counter.
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned CW       = 10,
    parameter int unsigned FCW      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    output logic           HS,
    output logic           VS,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           blank,
    output logic           pix_en,
    output logic           newline,
    output logic           newframe,
    output logic           endframe,
    output logic [FCW-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);
    localparam logic          HS_ON  = 1'(HS_POL);
    localparam logic          VS_ON  = 1'(VS_POL);

    // Reject configurations whose counters or fields cannot be represented.
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        CLK_DIV == 0 || CW == 0 || CW > 31 || FCW == 0 ||
        HS_POL > 1 || VS_POL > 1 ||
        64'(H_TOTAL) > (64'd1 << CW) || 64'(V_TOTAL) > (64'd1 << CW)) begin : g_bad_param
        $fatal(1, "vga_timing_gen: invalid parameter set");
    end

    logic [PW-1:0]  p_q, p_d;
    logic [CW-1:0]  x_q, x_d;
    logic [CW-1:0]  y_q, y_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           blank_q, blank_d;
    logic           pix_en_q, pix_en_d;
    logic           newline_q, newline_d;
    logic           newframe_q, newframe_d;
    logic           endframe_q, endframe_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic           tick_c;

    // Reset parks every counter on its last value so the first enabled clk
    // wraps straight onto the frame origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= P_LAST;
            x_q        <= X_LAST;
            y_q        <= Y_LAST;
            hs_q       <= ~HS_ON;
            vs_q       <= ~VS_ON;
            blank_q    <= 1'b1;
            pix_en_q   <= 1'b0;
            newline_q  <= 1'b0;
            newframe_q <= 1'b0;
            endframe_q <= 1'b0;
            fc_q       <= '1;
        end else begin
            p_q        <= p_d;
            x_q        <= x_d;
            y_q        <= y_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            blank_q    <= blank_d;
            pix_en_q   <= pix_en_d;
            newline_q  <= newline_d;
            newframe_q <= newframe_d;
            endframe_q <= endframe_d;
            fc_q       <= fc_d;
        end
    end

    // Counter advance; outputs decode the next position so they line up with x/y.
    always_comb begin
        p_d        = p_q;
        x_d        = x_q;
        y_d        = y_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        blank_d    = blank_q;
        fc_d       = fc_q;
        tick_c     = en & (p_q == P_LAST);

        if (tick_c) begin
            p_d = '0;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end else if (en) begin
            p_d = p_q + PW'(1);
        end

        if (en) begin
            hs_d    = ((x_d >= CW'(HS_START)) && (x_d < CW'(HS_END))) ? HS_ON : ~HS_ON;
            vs_d    = ((y_d >= CW'(VS_START)) && (y_d < CW'(VS_END))) ? VS_ON : ~VS_ON;
            blank_d = (x_d >= CW'(H_ACTIVE)) || (y_d >= CW'(V_ACTIVE));
        end

        pix_en_d   = tick_c;
        newline_d  = tick_c & (x_d == '0);
        newframe_d = newline_d & (y_d == '0);
        endframe_d = newline_d & (y_d == CW'(V_ACTIVE));

        if (newframe_d) begin
            fc_d = fc_q + FCW'(1);
        end
    end

    assign HS        = hs_q;
    assign VS        = vs_q;
    assign x         = x_q;
    assign y         = y_q;
    assign blank     = blank_q;
    assign pix_en    = pix_en_q;
    assign newline   = newline_q;
    assign newframe  = newframe_q;
    assign endframe  = endframe_q;
    assign frame_cnt = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations share clk/en/rst_n and are
// scored every clk against an enabled-clk-count model, plus directed raster checks.
`timescale 1ns/1ps

module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    always #5 clk = ~clk;

    // {HS,VS,blank,pix_en,newline,newframe,endframe,x[9:0],y[9:0],frame_cnt[7:0]}
    wire [34:0] v_def, v_sm, v_md;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n), .en(en),
        .HS(v_def[34]), .VS(v_def[33]), .x(v_def[27:18]), .y(v_def[17:8]),
        .blank(v_def[32]), .pix_en(v_def[31]), .newline(v_def[30]),
        .newframe(v_def[29]), .endframe(v_def[28]), .frame_cnt(v_def[7:0])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1), .VS_POL(1)
    ) u_sm (
        .clk(clk), .rst_n(rst_n), .en(en),
        .HS(v_sm[34]), .VS(v_sm[33]), .x(v_sm[27:18]), .y(v_sm[17:8]),
        .blank(v_sm[32]), .pix_en(v_sm[31]), .newline(v_sm[30]),
        .newframe(v_sm[29]), .endframe(v_sm[28]), .frame_cnt(v_sm[7:0])
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(3), .HS_POL(0), .VS_POL(0)
    ) u_md (
        .clk(clk), .rst_n(rst_n), .en(en),
        .HS(v_md[34]), .VS(v_md[33]), .x(v_md[27:18]), .y(v_md[17:8]),
        .blank(v_md[32]), .pix_en(v_md[31]), .newline(v_md[30]),
        .newframe(v_md[29]), .endframe(v_md[28]), .frame_cnt(v_md[7:0])
    );

    int n_chk = 0;
    int n_err = 0;
    int k     = 0;   // enabled clk edges since reset release
    int cyc   = 0;

    logic [34:0] q_def[$];
    logic [34:0] q_sm[$];
    logic [34:0] q_md[$];
    logic [34:0] prev_def, prev_sm;

    int hs_fall_x = -1, hs_rise_x = -1, blank_rise_x = -1;
    int nl_n = 0;
    int nl_t[2] = '{0, 0};
    int sm_pix_gap = 0;
    int sm_hs_min = 1000, sm_hs_max = -1, sm_vs_min = 1000, sm_vs_max = -1;
    int sm_wrap_k = -1;
    int md_ef_x = -1, md_ef_y = -1;
    int md_vs_min = 1000, md_vs_max = -1;

    task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outputs from the count of enabled clks: pixel = (k-1)/div, etc.
    function automatic logic [34:0] model(input int ha, input int hf, input int hs, input int hb,
                                          input int va, input int vf, input int vs, input int vb,
                                          input int d, input bit hpol, input bit vpol,
                                          input int kk, input bit e);
        int ht, vt, pix, p, xx, yy, f;
        bit hsv, vsv, bl, pe, nl, nf, ef;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (kk == 0) return {~hpol, ~vpol, 1'b1, 4'b0000, 10'(ht - 1), 10'(vt - 1), 8'hFF};
        pix = (kk - 1) / d;
        p   = (kk - 1) % d;
        xx  = pix % ht;
        yy  = (pix / ht) % vt;
        f   = pix / (ht * vt);
        hsv = (xx >= ha + hf && xx < ha + hf + hs) ? hpol : ~hpol;
        vsv = (yy >= va + vf && yy < va + vf + vs) ? vpol : ~vpol;
        bl  = (xx >= ha) || (yy >= va);
        pe  = e && (p == 0);
        nl  = pe && (xx == 0);
        nf  = nl && (yy == 0);
        ef  = nl && (yy == va);
        return {hsv, vsv, bl, pe, nl, nf, ef, 10'(xx), 10'(yy), 8'(f)};
    endfunction

    function automatic logic [34:0] exp_def(input int kk, input bit e);
        return model(640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0, kk, e);
    endfunction
    function automatic logic [34:0] exp_sm(input int kk, input bit e);
        return model(8, 1, 2, 1, 4, 1, 1, 1, 1, 1'b1, 1'b1, kk, e);
    endfunction
    function automatic logic [34:0] exp_md(input int kk, input bit e);
        return model(16, 2, 3, 2, 12, 2, 2, 3, 3, 1'b0, 1'b0, kk, e);
    endfunction

    // One clk: drive en, push expectations, then compare after the edge.
    task automatic step(input bit e);
        int xv, yv;
        @(negedge clk);
        en = e;
        if (e) k++;
        q_def.push_back(exp_def(k, e));
        q_sm.push_back(exp_sm(k, e));
        q_md.push_back(exp_md(k, e));
        @(posedge clk);
        #1;
        cyc++;
        chk("def", v_def, q_def.pop_front());
        chk("sm", v_sm, q_sm.pop_front());
        chk("md", v_md, q_md.pop_front());

        xv = int'(v_def[27:18]);
        if (prev_def[34] && !v_def[34] && hs_fall_x < 0) hs_fall_x = xv;
        if (!prev_def[34] && v_def[34] && hs_rise_x < 0 && hs_fall_x >= 0) hs_rise_x = xv;
        if (!prev_def[32] && v_def[32] && blank_rise_x < 0) blank_rise_x = xv;
        if (v_def[30] && nl_n < 2) begin
            nl_t[nl_n] = cyc;
            nl_n++;
        end

        xv = int'(v_sm[27:18]);
        yv = int'(v_sm[17:8]);
        if (e && !v_sm[31]) sm_pix_gap++;
        if (k > 0 && v_sm[34]) begin
            if (xv < sm_hs_min) sm_hs_min = xv;
            if (xv > sm_hs_max) sm_hs_max = xv;
        end
        if (k > 0 && v_sm[33]) begin
            if (yv < sm_vs_min) sm_vs_min = yv;
            if (yv > sm_vs_max) sm_vs_max = yv;
        end
        if (k > 1 && prev_sm[7:0] == 8'hFF && v_sm[7:0] == 8'h00 && sm_wrap_k < 0) sm_wrap_k = k;

        yv = int'(v_md[17:8]);
        if (v_md[28] && md_ef_y < 0) begin
            md_ef_x = int'(v_md[27:18]);
            md_ef_y = yv;
        end
        if (k > 0 && !v_md[33]) begin
            if (yv < md_vs_min) md_vs_min = yv;
            if (yv > md_vs_max) md_vs_max = yv;
        end

        prev_def = v_def;
        prev_sm  = v_sm;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_def", v_def, exp_def(0, 1'b0));
        chk("rst_sm", v_sm, exp_sm(0, 1'b0));
        chk("rst_md", v_md, exp_md(0, 1'b0));
        prev_def = v_def;
        prev_sm  = v_sm;
        @(negedge clk);
        rst_n = 1'b1;

        // First clk after release must land on the frame origin.
        step(1'b1);
        chk("first_clk", v_def, {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 8'd0});
        repeat (3300) step(1'b1);

        // Freeze mid-pixel for 7 clks, then resume.
        while (((k - 1) % 4) != 1) step(1'b1);
        repeat (7) step(1'b0);
        repeat (60) step(1'b1);

        // Asynchronous reset between clk edges.
        en    = 1'b0;
        rst_n = 1'b0;
        #2;
        k = 0;
        chk("arst_def", v_def, exp_def(0, 1'b0));
        chk("arst_sm", v_sm, exp_sm(0, 1'b0));
        chk("arst_md", v_md, exp_md(0, 1'b0));
        prev_def = v_def;
        prev_sm  = v_sm;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        chk("arst_newframe", 35'(v_def[29]), 35'(1));

        repeat (22000) step(1'b1);

        chk("hs_fall_x", 35'(hs_fall_x), 35'(656));
        chk("hs_rise_x", 35'(hs_rise_x), 35'(752));
        chk("blank_rise_x", 35'(blank_rise_x), 35'(640));
        chk("newline_period", 35'(nl_t[1] - nl_t[0]), 35'(3200));
        chk("sm_pix_gap", 35'(sm_pix_gap), 35'(0));
        chk("sm_hs_min", 35'(sm_hs_min), 35'(9));
        chk("sm_hs_max", 35'(sm_hs_max), 35'(10));
        chk("sm_vs_min", 35'(sm_vs_min), 35'(5));
        chk("sm_vs_max", 35'(sm_vs_max), 35'(5));
        chk("sm_wrap_k", 35'(sm_wrap_k), 35'(256 * 84 + 1));
        chk("md_endframe_x", 35'(md_ef_x), 35'(0));
        chk("md_endframe_y", 35'(md_ef_y), 35'(12));
        chk("md_vs_min", 35'(md_vs_min), 35'(14));
        chk("md_vs_max", 35'(md_vs_max), 35'(15));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
